bmem_arbiter: RTL

//  Memory-side stage of the CPU, directly upstream of the banked memory port (bmem_*).

---
 rtl/mem_pkg.sv | 20 ++
 rtl/bmem_rd_assembler.sv | 48 ++++
 rtl/bmem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths, line/beat types and issue-FSM state encoding for the bmem arbiter.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  // state  | meaning
  // IDLE   | arbitrate and issue a read command or write beat 0
  // WBURST | stream write beats 1..BEATS-1 of the accepted line
  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } state_t;

endpackage

// File: rtl/bmem_rd_assembler.sv
// Collects a burst of read beats into a full line and flags the cycle after the last beat.
module bmem_rd_assembler #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rvalid,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [BEAT_W-1:0] i_rdata,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [LINE_W-1:0] o_line
);
  import mem_pkg::*;

  localparam int                CNT_W = $clog2(LINE_W / BEAT_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_W / BEAT_W - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_done;

  // Shift beats into the line buffer; capture raddr on beat 0, pulse done after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_buf   <= '0;
      r_raddr <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_rvalid) begin
        r_buf[r_cnt*BEAT_W +: BEAT_W] <= i_rdata;
        if (r_cnt == '0) r_raddr <= i_raddr;
        if (r_cnt == LAST) r_done <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_done  = r_done;
  assign o_raddr = r_raddr;
  assign o_line  = r_buf;

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto the 64-bit bmem port, serializes
// write lines and routes reassembled read bursts back to whichever slot they match.
module bmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              err_unexp
);
  import mem_pkg::*;

  localparam int                CNT_W = $clog2(LINE_W / BEAT_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_W / BEAT_W - 1);

  state_t            r_state, w_state_nxt;
  logic              r_i_valid, r_d_valid;
  logic [ADDR_W-1:0] r_i_addr, r_d_addr, r_waddr;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_wresp;
  logic              r_rr_d;
  logic              r_err;
  logic [LINE_W-1:0] r_i_rdata, r_d_rdata;

  logic              w_done;
  logic [ADDR_W-1:0] w_raddr;
  logic [LINE_W-1:0] w_line;
  logic              w_match_i, w_match_d;
  logic              w_hazard, w_i_elig, w_d_elig;
  logic              w_gnt_i, w_gnt_d, w_accept;

  bmem_rd_assembler #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W)
  ) u_rd_asm (
    .clk      (clk),
    .rst      (rst),
    .i_rvalid (bmem_rvalid),
    .i_raddr  (bmem_raddr),
    .i_rdata  (bmem_rdata),
    .o_done   (w_done),
    .o_raddr  (w_raddr),
    .o_line   (w_line)
  );

  assign w_match_i = w_done && r_i_valid && (w_raddr == r_i_addr);
  assign w_match_d = w_done && r_d_valid && (w_raddr == r_d_addr);

  // A write to the line the I-cache is still fetching waits until that fetch completes.
  assign w_hazard = r_i_valid && (r_i_addr == d_addr);
  assign w_i_elig = i_read && !r_i_valid;
  assign w_d_elig = (d_read || d_write) && !r_d_valid && !r_wresp && !(d_write && w_hazard);
  assign w_gnt_d  = w_d_elig && (!w_i_elig || r_rr_d);
  assign w_gnt_i  = w_i_elig && !w_gnt_d;

  // Issue FSM next-state and bmem command outputs; commands are forced low while in reset.
  always_comb begin
    w_state_nxt = r_state;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_addr   = '0;
    bmem_wdata  = '0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_i) begin
          bmem_read = 1'b1;
          bmem_addr = i_addr;
          w_accept  = bmem_ready;
        end else if (w_gnt_d) begin
          bmem_addr = d_addr;
          w_accept  = bmem_ready;
          if (d_write) begin
            bmem_write = 1'b1;
            bmem_wdata = d_wdata[BEAT_W-1:0];
            if (bmem_ready) w_state_nxt = WBURST;
          end else begin
            bmem_read = 1'b1;
          end
        end
      end
      WBURST: begin
        bmem_write = 1'b1;
        bmem_addr  = r_waddr;
        bmem_wdata = d_wdata[r_wcnt*BEAT_W +: BEAT_W];
        if (r_wcnt == LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Round-robin pointer and outstanding read slots: set on accepted issue, cleared on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_d    <= 1'b0;
      r_i_valid <= 1'b0;
      r_i_addr  <= '0;
      r_d_valid <= 1'b0;
      r_d_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_rr_d <= ~r_rr_d;
        if (w_gnt_i) begin
          r_i_valid <= 1'b1;
          r_i_addr  <= i_addr;
        end else if (d_read) begin
          r_d_valid <= 1'b1;
          r_d_addr  <= d_addr;
        end
      end
      if (w_match_i) r_i_valid <= 1'b0;
      if (w_match_d) r_d_valid <= 1'b0;
    end
  end

  // Write burst beat counter, latched address and the write-completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_waddr <= '0;
      r_wresp <= 1'b0;
    end else begin
      r_wresp <= 1'b0;
      if (r_state == IDLE && w_accept && w_gnt_d && d_write) begin
        r_waddr <= d_addr;
        r_wcnt  <= CNT_W'(1);
      end else if (r_state == WBURST) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == LAST) r_wresp <= 1'b1;
      end
    end
  end

  // Hold returned lines per requester and flag bursts that match no outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_match_i) r_i_rdata <= w_line;
      if (w_match_d) r_d_rdata <= w_line;
      if (w_done && !w_match_i && !w_match_d) r_err <= 1'b1;
    end
  end

  assign i_resp    = w_match_i;
  assign d_resp    = w_match_d || r_wresp;
  assign i_rdata   = w_match_i ? w_line : r_i_rdata;
  assign d_rdata   = w_match_d ? w_line : r_d_rdata;
  assign err_unexp = r_err;

endmodule
